program_counter_unit: RTL and testbench

- Parametrised next-generation fetch PC register for the RISC-Net core.
- Selects the next PC from sequential, jump, call, return and late branch-redirect sources, and honours stall (PCWrite).
- Contains a small circular return-address stack (RAS) so that Ret resolves in fetch without a register-file read.
- Sits between the fetch-stage adder/mux logic and instruction memory; PCResult drives the IMEM address.

---
 rtl/program_counter_unit_pkg.sv | 18 +
 rtl/program_counter_unit_if.sv | 28 ++
 rtl/program_counter_unit_ras.sv | 61 ++++++
 rtl/program_counter_unit.sv | 95 +++++++++
 tb/tb_program_counter_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/program_counter_unit_pkg.sv
// Shared types and helpers for the fetch PC unit and its return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_BRANCH,
    SEL_RET,
    SEL_CALL,
    SEL_JUMP,
    SEL_SEQ
  } pc_sel_e;

  // Pointer width for the RAS; at least one bit so a depth of 2 still indexes.
  function automatic int ras_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/program_counter_unit_if.sv
// Fetch-control bundle between the fetch stage and the PC unit.
interface pc_if #(
  parameter int WIDTH = 16
);
  logic             PCWrite;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             Jump;
  logic             Call;
  logic [WIDTH-1:0] JumpTarget;
  logic             Ret;
  logic [WIDTH-1:0] PCResult;
  logic [WIDTH-1:0] PCPlusInc;
  logic             RasEmpty;
  logic             RasFull;
  logic             RasOverflow;
  logic             RasUnderflow;

  modport slave (
    input  PCWrite, BranchTaken, BranchTarget, Jump, Call, JumpTarget, Ret,
    output PCResult, PCPlusInc, RasEmpty, RasFull, RasOverflow, RasUnderflow
  );

  modport master (
    output PCWrite, BranchTaken, BranchTarget, Jump, Call, JumpTarget, Ret,
    input  PCResult, PCPlusInc, RasEmpty, RasFull, RasOverflow, RasUnderflow
  );
endinterface

// File: rtl/program_counter_unit_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full.
module return_addr_stack
  import pc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow
);
  localparam int PW = ras_ptr_w(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [RAS_DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PW-1:0]                   ptr_q, ptr_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            ovf_q, ovf_d;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == DEPTH_C);
  assign overflow = ovf_q;
  assign top      = mem_q[ptr_q];

  // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (push) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = full ? cnt_q : cnt_q + 1'b1;
      ovf_d = ovf_q | full;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mem_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (push) mem_q[ptr_d] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch PC register: prioritised next-PC selection with stall and a return-address stack.
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter int               INC          = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input logic  Clk,
  input logic  Reset,
  pc_if.slave  bus
);
  localparam logic [WIDTH-1:0] INC_C = WIDTH'(INC);

  pc_sel_e          sel;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty, ras_full, ras_ovf;
  logic             ras_push, ras_pop;

  assign pc_inc = pc_q + INC_C;

  // Redirect priority: stall, late branch, return, call, jump, sequential.
  always_comb begin
    sel = SEL_SEQ;
    if (!bus.PCWrite)        sel = SEL_HOLD;
    else if (bus.BranchTaken) sel = SEL_BRANCH;
    else if (bus.Ret)         sel = SEL_RET;
    else if (bus.Call)        sel = SEL_CALL;
    else if (bus.Jump)        sel = SEL_JUMP;
  end

  always_comb begin
    pc_d     = pc_q;
    udf_d    = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    unique case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_BRANCH: pc_d = bus.BranchTarget;
      SEL_RET: begin
        if (ras_empty) begin
          pc_d  = pc_inc;
          udf_d = 1'b1;
        end else begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end
      end
      SEL_CALL: begin
        pc_d     = bus.JumpTarget;
        ras_push = 1'b1;
      end
      SEL_JUMP:   pc_d = bus.JumpTarget;
      SEL_SEQ:    pc_d = pc_inc;
      default:    pc_d = pc_q;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pc_q  <= RESET_VECTOR;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      udf_q <= udf_d;
    end
  end

  return_addr_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_ovf)
  );

  assign bus.PCResult     = pc_q;
  assign bus.PCPlusInc    = pc_inc;
  assign bus.RasEmpty     = ras_empty;
  assign bus.RasFull      = ras_full;
  assign bus.RasOverflow  = ras_ovf;
  assign bus.RasUnderflow = udf_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Directed bench for program_counter_unit (WIDTH=16, INC=1, RAS_DEPTH=4).
module tb_program_counter_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pc_if #(.WIDTH(16)) bus ();

  program_counter_unit #(
    .WIDTH        (16),
    .INC          (1),
    .RESET_VECTOR (16'h0000),
    .RAS_DEPTH    (4)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.PCWrite      = 1'b1;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = '0;
    bus.Jump         = 1'b0;
    bus.Call         = 1'b0;
    bus.JumpTarget   = '0;
    bus.Ret          = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump_to(input logic [15:0] a);
    bus.Jump = 1'b1; bus.JumpTarget = a;
    step();
    idle();
  endtask

  task automatic call_at(input logic [15:0] a, input logic [15:0] tgt);
    jump_to(a);
    bus.Call = 1'b1; bus.JumpTarget = tgt;
    step();
    idle();
  endtask

  task automatic ret();
    bus.Ret = 1'b1;
    step();
    idle();
  endtask

  logic [15:0] exp_ret [4] = '{16'h0051, 16'h0041, 16'h0031, 16'h0021};

  initial begin
    idle();
    #12 rst = 1'b0;
    step(); step();
    // 1: asynchronous reset mid-cycle, then sequential count
    check("pre_reset_pc", bus.PCResult, 16'h0002);
    #3 rst = 1'b1;
    #1;
    check("async_reset_pc", bus.PCResult, 16'h0000);
    check("reset_empty", bus.RasEmpty, 1'b1);
    check("reset_full", bus.RasFull, 1'b0);
    check("reset_ovf", bus.RasOverflow, 1'b0);
    check("reset_udf", bus.RasUnderflow, 1'b0);
    check("reset_plusinc", bus.PCPlusInc, 16'h0001);
    step();
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_pc", bus.PCResult, i);
    end

    // 2: stall holds everything
    jump_to(16'h0020);
    check("jump_pc", bus.PCResult, 16'h0020);
    bus.PCWrite = 1'b0; bus.BranchTaken = 1'b1; bus.BranchTarget = 16'h0040; bus.Call = 1'b1;
    step();
    check("stall_pc", bus.PCResult, 16'h0020);
    check("stall_empty", bus.RasEmpty, 1'b1);
    bus.PCWrite = 1'b1;
    step();
    idle();
    check("branch_pc", bus.PCResult, 16'h0040);
    check("branch_over_call_empty", bus.RasEmpty, 1'b1);

    // 3: call/return pair
    call_at(16'h0010, 16'h0100);
    check("call_pc", bus.PCResult, 16'h0100);
    check("call_not_empty", bus.RasEmpty, 1'b0);
    ret();
    check("ret_pc", bus.PCResult, 16'h0011);
    check("ret_empty", bus.RasEmpty, 1'b1);

    // 4: fill, overflow, drain, underflow
    for (int i = 1; i <= 5; i++) begin
      call_at(16'(i * 16), 16'h0300);
      if (i == 4) begin
        check("full_after4", bus.RasFull, 1'b1);
        check("no_ovf_after4", bus.RasOverflow, 1'b0);
      end
    end
    check("ovf_after5", bus.RasOverflow, 1'b1);
    check("full_after5", bus.RasFull, 1'b1);
    for (int i = 0; i < 4; i++) begin
      ret();
      check("drain_pc", bus.PCResult, exp_ret[i]);
      check("drain_no_udf", bus.RasUnderflow, 1'b0);
    end
    check("drained_empty", bus.RasEmpty, 1'b1);
    ret();
    check("udf_pc", bus.PCResult, 16'h0022);
    check("udf_pulse", bus.RasUnderflow, 1'b1);
    step();
    check("udf_clear", bus.RasUnderflow, 1'b0);
    check("udf_next_pc", bus.PCResult, 16'h0023);
    check("ovf_sticky", bus.RasOverflow, 1'b1);
    // Ret beats Call while empty: underflow, no push
    bus.Ret = 1'b1; bus.Call = 1'b1; bus.JumpTarget = 16'h0700;
    step();
    idle();
    check("ret_over_call_pc", bus.PCResult, 16'h0024);
    check("ret_over_call_udf", bus.RasUnderflow, 1'b1);
    check("ret_over_call_empty", bus.RasEmpty, 1'b1);
    rst = 1'b1;
    #1;
    check("ovf_reset", bus.RasOverflow, 1'b0);
    step();
    rst = 1'b0;

    // 5: wraparound
    jump_to(16'hFFFF);
    check("max_plusinc", bus.PCPlusInc, 16'h0000);
    step();
    check("wrap_pc", bus.PCResult, 16'h0000);
    check("wrap_plusinc", bus.PCPlusInc, 16'h0001);
    call_at(16'hFFFF, 16'h0500);
    check("wrap_call_pc", bus.PCResult, 16'h0500);
    ret();
    check("wrap_push_val", bus.PCResult, 16'h0000);

    // 6: branch beats ret, RAS untouched
    call_at(16'h0010, 16'h0100);
    bus.BranchTaken = 1'b1; bus.BranchTarget = 16'h0200; bus.Ret = 1'b1;
    step();
    idle();
    check("branch_over_ret_pc", bus.PCResult, 16'h0200);
    check("branch_over_ret_empty", bus.RasEmpty, 1'b0);
    ret();
    check("after_branch_ret_pc", bus.PCResult, 16'h0011);
    check("after_branch_ret_empty", bus.RasEmpty, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
